coder_block_sequencer: RTL and testbench

Controller that sequences the three input streams of the CODER (mapped error `ehat`, Golomb parameter `kj`, block flag `d_flag`) on a per-block basis for one image and closes the image with a flush handshake. It sits between the predictor/parameter stage outputs and the CODER inputs. It enforces one `d_flag` per block and exactly 2**BLOCK_SIZE_LOG `ehat` per block. It drops `kj` values the CODER does not consume, replacing the ad-hoc stream reducer used around the coder.

---
 rtl/coder_pkg.sv | 19 +
 rtl/coder_block_sequencer_if.sv | 56 +++++
 rtl/stream_block_counter.sv | 34 +++
 rtl/coder_block_sequencer.sv | 153 +++++++++++++++
 tb/tb_coder_block_sequencer.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/coder_pkg.sv
// Shared types and helpers for the CODER block sequencer.
package coder_pkg;

    localparam int unsigned BLOCK_SIZE_LOG_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FLAG  = 3'd1,
        DATA  = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } coder_seq_state_t;

    // Samples per block derived from its log2.
    function automatic int unsigned block_size(input int unsigned size_log);
        return 32'(1) << size_log;
    endfunction

endpackage

// File: rtl/coder_block_sequencer_if.sv
// Control, upstream and CODER-side stream signals of the block sequencer.
interface coder_block_sequencer_if #(
    parameter int unsigned MAPPED_ERROR_WIDTH = 19,
    parameter int unsigned ACC_LOG            = 5,
    parameter int unsigned BLOCK_COUNT_WIDTH  = 16
);
    logic                          start;
    logic [BLOCK_COUNT_WIDTH-1:0]  block_count;
    logic                          busy;
    logic                          done;

    logic [MAPPED_ERROR_WIDTH-1:0] in_ehat_data;
    logic                          in_ehat_valid;
    logic                          in_ehat_ready;
    logic [ACC_LOG-1:0]            in_kj_data;
    logic                          in_kj_valid;
    logic                          in_kj_ready;
    logic                          in_d_flag_data;
    logic                          in_d_flag_valid;
    logic                          in_d_flag_ready;

    logic [MAPPED_ERROR_WIDTH-1:0] ehat_data;
    logic                          ehat_valid;
    logic                          ehat_ready;
    logic [ACC_LOG-1:0]            kj_data;
    logic                          kj_valid;
    logic                          kj_ready;
    logic                          d_flag_data;
    logic                          d_flag_valid;
    logic                          d_flag_ready;

    logic                          flush;
    logic                          flushed;

    // Sequencer side.
    modport master (
        input  start, block_count,
        input  in_ehat_data, in_ehat_valid, in_kj_data, in_kj_valid,
        input  in_d_flag_data, in_d_flag_valid,
        input  ehat_ready, kj_ready, d_flag_ready, flushed,
        output busy, done, flush,
        output in_ehat_ready, in_kj_ready, in_d_flag_ready,
        output ehat_data, ehat_valid, kj_data, kj_valid, d_flag_data, d_flag_valid
    );

    // Environment side (upstream producers and CODER).
    modport slave (
        output start, block_count,
        output in_ehat_data, in_ehat_valid, in_kj_data, in_kj_valid,
        output in_d_flag_data, in_d_flag_valid,
        output ehat_ready, kj_ready, d_flag_ready, flushed,
        input  busy, done, flush,
        input  in_ehat_ready, in_kj_ready, in_d_flag_ready,
        input  ehat_data, ehat_valid, kj_data, kj_valid, d_flag_data, d_flag_valid
    );
endinterface

// File: rtl/stream_block_counter.sv
// Counts stream handshakes within one block, saturating at BLOCK_SIZE.
module stream_block_counter
    import coder_pkg::*;
#(
    parameter int unsigned BLOCK_SIZE_LOG = BLOCK_SIZE_LOG_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_clear,
    input  logic                    i_inc,
    output logic [BLOCK_SIZE_LOG:0] o_idx,
    output logic                    o_last,
    output logic                    o_done
);
    localparam int unsigned     CNT_W = BLOCK_SIZE_LOG + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(block_size(BLOCK_SIZE_LOG));

    logic [CNT_W-1:0] r_count;

    // Handshake counter; clear has priority, stops once the block is complete.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != FULL)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_idx  = r_count;
    assign o_last = (r_count == (FULL - CNT_W'(1)));
    assign o_done = (r_count == FULL);
endmodule

// File: rtl/coder_block_sequencer.sv
// Sequences d_flag / ehat / kj per block into the CODER and flushes at image end.
module coder_block_sequencer
    import coder_pkg::*;
#(
    parameter int unsigned MAPPED_ERROR_WIDTH = 19,
    parameter int unsigned ACC_LOG            = 5,
    parameter int unsigned BLOCK_SIZE_LOG     = BLOCK_SIZE_LOG_DEFAULT,
    parameter int unsigned BLOCK_COUNT_WIDTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    coder_block_sequencer_if.master  bus
);
    localparam int unsigned BLOCK_SIZE = block_size(BLOCK_SIZE_LOG);
    localparam int unsigned CNT_W      = BLOCK_SIZE_LOG + 1;

    coder_seq_state_t              r_state, w_state_nxt;
    logic [BLOCK_COUNT_WIDTH-1:0]  r_blocks_left, w_blocks_left_nxt;
    logic                          r_flag_q, w_flag_q_nxt;
    logic                          r_busy, r_done, r_flush;
    logic                          w_cnt_clear;
    logic                          w_ehat_valid, w_in_ehat_ready;
    logic                          w_kj_valid, w_in_kj_ready;
    logic                          w_d_flag_valid, w_in_d_flag_ready;
    logic                          w_ehat_fin, w_kj_fin;
    logic                          w_ehat_hs, w_kj_hs;
    logic [CNT_W-1:0]              w_ehat_idx, w_kj_idx;
    logic                          w_ehat_last, w_ehat_done, w_kj_last, w_kj_done;
    logic                          w_ehat_open, w_kj_open, w_kj_fwd;

    assign w_ehat_hs   = bus.in_ehat_valid & w_in_ehat_ready;
    assign w_kj_hs     = bus.in_kj_valid & w_in_kj_ready;
    assign w_ehat_open = (w_ehat_idx < CNT_W'(BLOCK_SIZE));
    assign w_kj_open   = !w_kj_done;
    // The last kj of a block, and every kj of a flagged block, is not used by the CODER.
    assign w_kj_fwd    = !r_flag_q && (w_kj_idx < CNT_W'(BLOCK_SIZE - 1));

    stream_block_counter #(.BLOCK_SIZE_LOG(BLOCK_SIZE_LOG)) u_ehat_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_cnt_clear),
        .i_inc   (w_ehat_hs),
        .o_idx   (w_ehat_idx),
        .o_last  (w_ehat_last),
        .o_done  (w_ehat_done)
    );

    stream_block_counter #(.BLOCK_SIZE_LOG(BLOCK_SIZE_LOG)) u_kj_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_cnt_clear),
        .i_inc   (w_kj_hs),
        .o_idx   (w_kj_idx),
        .o_last  (w_kj_last),
        .o_done  (w_kj_done)
    );

    // Next-state and stream gating.
    always_comb begin
        w_state_nxt       = r_state;
        w_blocks_left_nxt = r_blocks_left;
        w_flag_q_nxt      = r_flag_q;
        w_cnt_clear       = 1'b0;
        w_ehat_valid      = 1'b0;
        w_in_ehat_ready   = 1'b0;
        w_kj_valid        = 1'b0;
        w_in_kj_ready     = 1'b0;
        w_d_flag_valid    = 1'b0;
        w_in_d_flag_ready = 1'b0;
        w_ehat_fin        = 1'b0;
        w_kj_fin          = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_blocks_left_nxt = bus.block_count;
                    w_state_nxt       = (bus.block_count != '0) ? FLAG : FLUSH;
                end
            end
            FLAG: begin
                w_d_flag_valid    = bus.in_d_flag_valid;
                w_in_d_flag_ready = bus.d_flag_ready;
                if (bus.in_d_flag_valid && bus.d_flag_ready) begin
                    w_flag_q_nxt = bus.in_d_flag_data;
                    w_cnt_clear  = 1'b1;
                    w_state_nxt  = DATA;
                end
            end
            DATA: begin
                if (w_ehat_open) begin
                    w_ehat_valid    = bus.in_ehat_valid;
                    w_in_ehat_ready = bus.ehat_ready;
                end
                if (w_kj_open) begin
                    if (w_kj_fwd) begin
                        w_kj_valid    = bus.in_kj_valid;
                        w_in_kj_ready = bus.kj_ready;
                    end else begin
                        w_in_kj_ready = 1'b1;
                    end
                end
                w_ehat_fin = w_ehat_done || (w_ehat_last && bus.in_ehat_valid && w_in_ehat_ready);
                w_kj_fin   = w_kj_done || (w_kj_last && bus.in_kj_valid && w_in_kj_ready);
                if (w_ehat_fin && w_kj_fin) begin
                    w_blocks_left_nxt = r_blocks_left - BLOCK_COUNT_WIDTH'(1);
                    w_state_nxt       = (r_blocks_left == BLOCK_COUNT_WIDTH'(1)) ? FLUSH : FLAG;
                end
            end
            FLUSH: begin
                if (bus.flushed) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, block bookkeeping and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_blocks_left <= '0;
            r_flag_q      <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_flush       <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_blocks_left <= w_blocks_left_nxt;
            r_flag_q      <= w_flag_q_nxt;
            r_busy        <= (w_state_nxt == FLAG) || (w_state_nxt == DATA) || (w_state_nxt == FLUSH);
            r_done        <= (w_state_nxt == DONE);
            r_flush       <= (w_state_nxt == FLUSH);
        end
    end

    assign bus.busy            = r_busy;
    assign bus.done            = r_done;
    assign bus.flush           = r_flush;
    assign bus.ehat_data       = MAPPED_ERROR_WIDTH'(bus.in_ehat_data);
    assign bus.ehat_valid      = w_ehat_valid;
    assign bus.in_ehat_ready   = w_in_ehat_ready;
    assign bus.kj_data         = ACC_LOG'(bus.in_kj_data);
    assign bus.kj_valid        = w_kj_valid;
    assign bus.in_kj_ready     = w_in_kj_ready;
    assign bus.d_flag_data     = bus.in_d_flag_data;
    assign bus.d_flag_valid    = w_d_flag_valid;
    assign bus.in_d_flag_ready = w_in_d_flag_ready;
endmodule

// File: tb/tb_coder_block_sequencer.sv
// Self-checking bench for coder_block_sequencer with BLOCK_SIZE = 4.
module tb_coder_block_sequencer;
    localparam int BSL = 2;
    localparam int BS  = 4;
    localparam int EW  = 19;
    localparam int KW  = 5;
    localparam int CW  = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    coder_block_sequencer_if #(.MAPPED_ERROR_WIDTH(EW), .ACC_LOG(KW), .BLOCK_COUNT_WIDTH(CW)) bus ();

    coder_block_sequencer #(
        .MAPPED_ERROR_WIDTH (EW),
        .ACC_LOG            (KW),
        .BLOCK_SIZE_LOG     (BSL),
        .BLOCK_COUNT_WIDTH  (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [EW-1:0] q_ehat[$], cap_ehat[$], exp_ehat[$];
    logic [KW-1:0] q_kj[$],   cap_kj[$],   exp_kj[$];
    logic          q_flag[$], cap_flag[$], exp_flag[$];
    int p_ehat, p_kj, p_flag;
    bit h_ehat, h_kj, h_flag;
    int stall_pct = 0;
    bit flushed_tied = 1'b0;
    bit in_image = 1'b0;
    int flush_cycles, done_cnt, busy_gap;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit go();
        return int'($urandom_range(99)) >= stall_pct;
    endfunction

    // Reference: every ehat forwarded; kj forwarded only for flag 0 and index < BS-1.
    task automatic build_model();
        exp_ehat = {};
        exp_kj   = {};
        exp_flag = {};
        for (int b = 0; b < q_flag.size(); b++) begin
            exp_flag.push_back(q_flag[b]);
            for (int i = 0; i < BS; i++) begin
                exp_ehat.push_back(q_ehat[b*BS + i]);
                if (!q_flag[b] && (i < BS - 1)) exp_kj.push_back(q_kj[b*BS + i]);
            end
        end
    endtask

    // fmode: 0 all flags 0, 1 all flags 1, 2 random; negative base means random data.
    task automatic make_image(input int bc, input int fmode, input int ebase, input int kbase);
        q_flag = {};
        q_ehat = {};
        q_kj   = {};
        for (int b = 0; b < bc; b++)
            q_flag.push_back((fmode == 2) ? 1'($urandom_range(1)) : (fmode == 1));
        for (int i = 0; i < bc*BS; i++) begin
            q_ehat.push_back((ebase < 0) ? EW'($urandom) : EW'(ebase + i));
            q_kj.push_back((kbase < 0) ? KW'($urandom) : KW'(kbase + i));
        end
    endtask

    task automatic drive();
        bus.in_ehat_valid   = (p_ehat < q_ehat.size()) && (h_ehat || go());
        bus.in_ehat_data    = (p_ehat < q_ehat.size()) ? q_ehat[p_ehat] : '0;
        bus.in_kj_valid     = (p_kj < q_kj.size()) && (h_kj || go());
        bus.in_kj_data      = (p_kj < q_kj.size()) ? q_kj[p_kj] : '0;
        bus.in_d_flag_valid = (p_flag < q_flag.size()) && (h_flag || go());
        bus.in_d_flag_data  = (p_flag < q_flag.size()) ? q_flag[p_flag] : 1'b0;
        bus.ehat_ready      = go();
        bus.kj_ready        = go();
        bus.d_flag_ready    = go();
        bus.flushed         = flushed_tied || (flush_cycles >= 3);
    endtask

    // Sample at negedge, drive just after the next posedge.
    task automatic cycle();
        @(negedge clk);
        h_ehat = bus.in_ehat_valid && !bus.in_ehat_ready;
        h_kj   = bus.in_kj_valid && !bus.in_kj_ready;
        h_flag = bus.in_d_flag_valid && !bus.in_d_flag_ready;
        if (bus.in_ehat_valid && bus.in_ehat_ready) p_ehat++;
        if (bus.in_kj_valid && bus.in_kj_ready) p_kj++;
        if (bus.in_d_flag_valid && bus.in_d_flag_ready) p_flag++;
        if (bus.ehat_valid && bus.ehat_ready) cap_ehat.push_back(bus.ehat_data);
        if (bus.kj_valid && bus.kj_ready) cap_kj.push_back(bus.kj_data);
        if (bus.d_flag_valid && bus.d_flag_ready) cap_flag.push_back(bus.d_flag_data);
        if (bus.flush) flush_cycles++;
        if (bus.done) done_cnt++;
        if (in_image && !bus.busy && !bus.done) busy_gap++;
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic check_idle(input string tag);
        #1;
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_done"}, 32'(bus.done), 0);
        chk({tag, "_flush"}, 32'(bus.flush), 0);
        chk({tag, "_valids"}, {29'd0, bus.ehat_valid, bus.kj_valid, bus.d_flag_valid}, 0);
        chk({tag, "_readies"}, {29'd0, bus.in_ehat_ready, bus.in_kj_ready, bus.in_d_flag_ready}, 0);
    endtask

    task automatic begin_image(input int bc);
        p_ehat = 0; p_kj = 0; p_flag = 0;
        h_ehat = 0; h_kj = 0; h_flag = 0;
        cap_ehat = {}; cap_kj = {}; cap_flag = {};
        flush_cycles = 0; done_cnt = 0; busy_gap = 0;
        build_model();
        drive();
        bus.block_count = CW'(bc);
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        in_image = 1'b1;
    endtask

    task automatic finish_image(input int bc, input bit pulse_mid, input string tag);
        bit pulsed;
        pulsed = 1'b0;
        for (int c = 0; c < 600 && done_cnt == 0; c++) begin
            if (pulse_mid && !pulsed && cap_ehat.size() >= 1) begin
                bus.start = 1'b1;
                bus.block_count = CW'(5);
                pulsed = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            cycle();
        end
        bus.start = 1'b0;
        in_image = 1'b0;
        chk({tag, "_done_pulses"}, 32'(done_cnt), 1);
        chk({tag, "_flush_cycles"}, 32'(flush_cycles), flushed_tied ? 1 : 4);
        chk({tag, "_busy_gaps"}, 32'(busy_gap), 0);
        chk({tag, "_flag_len"}, 32'(cap_flag.size()), 32'(exp_flag.size()));
        for (int i = 0; i < cap_flag.size() && i < exp_flag.size(); i++)
            chk({tag, "_flag"}, 32'(cap_flag[i]), 32'(exp_flag[i]));
        chk({tag, "_ehat_len"}, 32'(cap_ehat.size()), 32'(exp_ehat.size()));
        for (int i = 0; i < cap_ehat.size() && i < exp_ehat.size(); i++)
            chk({tag, "_ehat"}, 32'(cap_ehat[i]), 32'(exp_ehat[i]));
        chk({tag, "_kj_len"}, 32'(cap_kj.size()), 32'(exp_kj.size()));
        for (int i = 0; i < cap_kj.size() && i < exp_kj.size(); i++)
            chk({tag, "_kj"}, 32'(cap_kj[i]), 32'(exp_kj[i]));
        chk({tag, "_kj_consumed"}, 32'(p_kj), 32'(bc*BS));
        chk({tag, "_ehat_consumed"}, 32'(p_ehat), 32'(bc*BS));
        chk({tag, "_flag_consumed"}, 32'(p_flag), 32'(bc));
        flush_cycles = 0;
        cycle();
        check_idle({tag, "_after"});
    endtask

    task automatic run_image(input int bc, input int fmode, input int eb, input int kb,
                             input bit pulse_mid, input string tag);
        make_image(bc, fmode, eb, kb);
        begin_image(bc);
        finish_image(bc, pulse_mid, tag);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.block_count = '0;
        bus.in_ehat_valid = 1'b0; bus.in_ehat_data = '0;
        bus.in_kj_valid = 1'b0;   bus.in_kj_data = '0;
        bus.in_d_flag_valid = 1'b0; bus.in_d_flag_data = 1'b0;
        bus.ehat_ready = 1'b0; bus.kj_ready = 1'b0; bus.d_flag_ready = 1'b0;
        bus.flushed = 1'b0;
        p_ehat = 0; p_kj = 0; p_flag = 0;
        flush_cycles = 0; done_cnt = 0; busy_gap = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle("reset");

        // Directed: two flag-0 blocks, sequential data.
        stall_pct = 0;
        run_image(2, 0, 0, 10, 1'b0, "two_blocks");

        // Flagged block: every kj consumed, none forwarded.
        run_image(1, 1, 100, 20, 1'b0, "flag1");

        // Empty image goes straight to flush.
        run_image(0, 0, 0, 0, 1'b0, "empty");

        // Random data, flags and backpressure over three blocks.
        stall_pct = 40;
        run_image(3, 2, -1, -1, 1'b0, "rand_a");
        stall_pct = 60;
        run_image(3, 2, -1, -1, 1'b0, "rand_b");

        // Reset after two ehat transfers, then a fresh image.
        stall_pct = 0;
        make_image(2, 0, 0, 10);
        begin_image(2);
        for (int c = 0; c < 100 && cap_ehat.size() < 2; c++) cycle();
        chk("mid_reset_reached", 32'(cap_ehat.size() >= 2), 1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        in_image = 1'b0;
        check_idle("mid_reset");
        cap_ehat = {}; cap_kj = {}; cap_flag = {};
        cycle();
        chk("post_reset_transfers", 32'(cap_ehat.size() + cap_kj.size() + cap_flag.size()), 0);
        stall_pct = 30;
        run_image(1, 0, -1, -1, 1'b0, "fresh");

        // flushed tied high, start pulsed during DATA.
        flushed_tied = 1'b1;
        stall_pct = 20;
        run_image(2, 2, -1, -1, 1'b1, "tied");
        flushed_tied = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
